// File: rtl/wave_ch_if.sv
// Register bus of the wave channel controller.
// Signals:
//   wr_en  - write strobe, sampled on the rising clock edge
//   rd_en  - read strobe, qualifies the combinational read mux
//   addr   - register offset (0..4 decoded, 5..7 unused)
//   wdata  - write data
//   rdata  - combinational read data from the channel
interface wave_ch_if;
    logic       wr_en;
    logic       rd_en;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;

    modport master (output wr_en, output rd_en, output addr, output wdata, input rdata);
    modport slave  (input wr_en, input rd_en, input addr, input wdata, output rdata);
endinterface

// File: rtl/wave_ch_ctrl.sv
// Wave channel controller: register file, frequency timer, wave sample
// position counter and length counter of a wavetable sound channel.
//
// Optional feature: define WAVE_CH_READBACK_EN to read the live frequency
// timer back through offsets 3 and 4; otherwise those offsets read fixed ones.
//
// Ports:
//   cery_2mhz - clock
//   apu_reset - asynchronous active-high reset
//   bus       - register bus (wave_ch_if.slave): wr_en/rd_en/addr/wdata/rdata
//   tmr_tick  - frequency timer advance strobe
//   len_tick  - length counter clock strobe
//   dac_en    - DAC enable (off0 bit7)
//   vol       - volume code (off2)
//   freq      - frequency register (off3/off4)
//   len_en    - length counter enable (off4 bit6)
//   active    - channel playing
//   trig      - one-cycle pulse on trigger
//   step      - one-cycle pulse when the timer wraps
//   wave_pos  - wave sample position
module wave_ch_ctrl #(
    parameter int unsigned FREQ_W = 11,
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned VOL_W  = 2,
    parameter int unsigned POS_W  = 5
) (
    input  logic              cery_2mhz,
    input  logic              apu_reset,
    wave_ch_if.slave          bus,
    input  logic              tmr_tick,
    input  logic              len_tick,
    output logic              dac_en,
    output logic [VOL_W-1:0]  vol,
    output logic [FREQ_W-1:0] freq,
    output logic              len_en,
    output logic              active,
    output logic              trig,
    output logic              step,
    output logic [POS_W-1:0]  wave_pos
);

    localparam int unsigned FHI_W = FREQ_W - 8;

    localparam logic [2:0] OFF_CTRL = 3'd0;
    localparam logic [2:0] OFF_LEN  = 3'd1;
    localparam logic [2:0] OFF_VOL  = 3'd2;
    localparam logic [2:0] OFF_FLO  = 3'd3;
    localparam logic [2:0] OFF_FHI  = 3'd4;

    logic              dac_en_q,   dac_en_d;
    logic [VOL_W-1:0]  vol_q,      vol_d;
    logic [FREQ_W-1:0] freq_q,     freq_d;
    logic              len_en_q,   len_en_d;
    logic              active_q,   active_d;
    logic              trig_q,     trig_d;
    logic              step_q,     step_d;
    logic [POS_W-1:0]  wave_pos_q, wave_pos_d;
    logic [LEN_W-1:0]  len_cnt_q,  len_cnt_d;
    logic              len_done_q, len_done_d;
    logic [FREQ_W-1:0] timer_q,    timer_d;

    logic              trigger_c;
    logic              len_wr_c;
    logic [7:0]        rdata_c;

    // Next-state: register writes, then trigger, then timer/length ticks
    always_comb begin
        dac_en_d   = dac_en_q;
        vol_d      = vol_q;
        freq_d     = freq_q;
        len_en_d   = len_en_q;
        active_d   = active_q;
        trig_d     = 1'b0;
        step_d     = 1'b0;
        wave_pos_d = wave_pos_q;
        len_cnt_d  = len_cnt_q;
        len_done_d = len_done_q;
        timer_d    = timer_q;
        trigger_c  = 1'b0;
        len_wr_c   = 1'b0;

        if (bus.wr_en) begin
            case (bus.addr)
                OFF_CTRL: begin
                    dac_en_d = bus.wdata[7];
                    if (!bus.wdata[7]) begin
                        active_d = 1'b0;
                    end
                end
                OFF_LEN: begin
                    len_cnt_d  = bus.wdata[LEN_W-1:0];
                    len_done_d = 1'b0;
                    len_wr_c   = 1'b1;
                end
                OFF_VOL: begin
                    vol_d = bus.wdata[VOL_W+4:5];
                end
                OFF_FLO: begin
                    freq_d[7:0] = bus.wdata;
                end
                OFF_FHI: begin
                    freq_d[FREQ_W-1:8] = bus.wdata[FHI_W-1:0];
                    len_en_d           = bus.wdata[6];
                    trigger_c          = bus.wdata[7];
                end
                default: ;
            endcase
        end

        if (trigger_c) begin
            // Trigger swallows same-cycle timer and length ticks; the timer
            // reloads from the frequency being written in this same cycle.
            active_d   = dac_en_q;
            timer_d    = freq_d;
            wave_pos_d = '0;
            trig_d     = 1'b1;
            if (len_done_q) begin
                len_cnt_d  = '0;
                len_done_d = 1'b0;
            end
        end else begin
            if (tmr_tick && active_q) begin
                if (&timer_q) begin
                    timer_d    = freq_d;
                    step_d     = 1'b1;
                    wave_pos_d = wave_pos_q + POS_W'(1);
                end else begin
                    timer_d = timer_q + FREQ_W'(1);
                end
            end
            // A length reload written this cycle wins over the tick
            if (len_tick && len_en_q && !len_done_q && !len_wr_c) begin
                if (&len_cnt_q) begin
                    len_done_d = 1'b1;
                    len_cnt_d  = '0;
                    active_d   = 1'b0;
                end else begin
                    len_cnt_d = len_cnt_q + LEN_W'(1);
                end
            end
        end
    end

    // State registers
    always_ff @(posedge cery_2mhz or posedge apu_reset) begin
        if (apu_reset) begin
            dac_en_q   <= 1'b0;
            vol_q      <= '0;
            freq_q     <= '0;
            len_en_q   <= 1'b0;
            active_q   <= 1'b0;
            trig_q     <= 1'b0;
            step_q     <= 1'b0;
            wave_pos_q <= '0;
            len_cnt_q  <= '0;
            len_done_q <= 1'b0;
            timer_q    <= '0;
        end else begin
            dac_en_q   <= dac_en_d;
            vol_q      <= vol_d;
            freq_q     <= freq_d;
            len_en_q   <= len_en_d;
            active_q   <= active_d;
            trig_q     <= trig_d;
            step_q     <= step_d;
            wave_pos_q <= wave_pos_d;
            len_cnt_q  <= len_cnt_d;
            len_done_q <= len_done_d;
            timer_q    <= timer_d;
        end
    end

    // Read mux; unimplemented bits read as ones
    always_comb begin
        rdata_c = 8'hFF;
        if (bus.rd_en) begin
            case (bus.addr)
                OFF_CTRL: rdata_c = {dac_en_q, 7'h7F};
                OFF_VOL:  rdata_c[VOL_W+4:5] = vol_q;
`ifdef WAVE_CH_READBACK_EN
                OFF_FLO:  rdata_c = timer_q[7:0];
                OFF_FHI:  rdata_c = {1'b1, len_en_q, 6'(timer_q[FREQ_W-1:8])};
`else
                OFF_FHI:  rdata_c = {1'b1, len_en_q, 6'h3F};
`endif
                default:  rdata_c = 8'hFF;
            endcase
        end
    end

    assign bus.rdata = rdata_c;

    assign dac_en   = dac_en_q;
    assign vol      = vol_q;
    assign freq     = freq_q;
    assign len_en   = len_en_q;
    assign active   = active_q;
    assign trig     = trig_q;
    assign step     = step_q;
    assign wave_pos = wave_pos_q;

endmodule

// File: tb/tb_wave_ch_ctrl.sv
// Directed bench for wave_ch_ctrl (default parameters). Expected values are
// queued when a step is driven and popped when the output is sampled.
module tb_wave_ch_ctrl;

    logic        clk;
    logic        rst;
    logic        tmr_tick;
    logic        len_tick;
    logic        dac_en;
    logic [1:0]  vol;
    logic [10:0] freq;
    logic        len_en;
    logic        active;
    logic        trig;
    logic        step;
    logic [4:0]  wave_pos;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    wave_ch_if bus();

    wave_ch_ctrl dut (
        .cery_2mhz (clk),
        .apu_reset (rst),
        .bus       (bus),
        .tmr_tick  (tmr_tick),
        .len_tick  (len_tick),
        .dac_en    (dac_en),
        .vol       (vol),
        .freq      (freq),
        .len_en    (len_en),
        .active    (active),
        .trig      (trig),
        .step      (step),
        .wave_pos  (wave_pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic chk(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
            end
        end
    endtask

    // One clock; outputs are stable 1 time unit after the rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        bus.wr_en = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        cyc();
        bus.wr_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic en, output logic [7:0] d);
        bus.rd_en = en;
        bus.addr  = a;
        #1;
        d = bus.rdata;
        bus.rd_en = 1'b0;
    endtask

    logic [7:0] r;

    initial begin
        rst       = 1'b1;
        tmr_tick  = 1'b0;
        len_tick  = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.addr  = 3'd0;
        bus.wdata = 8'h00;
        repeat (3) cyc();

        // Reset state
        push("rst_dac_en", 0);   chk(32'(dac_en));
        push("rst_active", 0);   chk(32'(active));
        push("rst_freq", 0);     chk(32'(freq));
        push("rst_trig", 0);     chk(32'(trig));
        rst = 1'b0;
        cyc();
        rd(3'd0, 1'b0, r);
        push("rd_disabled", 32'hFF); chk(32'(r));

        // Control / volume registers
        wr(3'd0, 8'h80);
        push("dac_en_set", 1);   chk(32'(dac_en));
        push("dac_no_active", 0); chk(32'(active));
        rd(3'd0, 1'b1, r);
        push("rd_off0", 32'hFF); chk(32'(r));
        wr(3'd2, 8'h20);
        push("vol_wr", 1);       chk(32'(vol));
        rd(3'd2, 1'b1, r);
        push("rd_off2", 32'hBF); chk(32'(r));

        // Trigger with freq 0x7FE
        wr(3'd3, 8'hFE);
        wr(3'd4, 8'h87);
        push("trig_pulse", 1);   chk(32'(trig));
        push("trig_active", 1);  chk(32'(active));
        push("trig_freq", 32'h7FE); chk(32'(freq));
        push("trig_pos", 0);     chk(32'(wave_pos));
        cyc();
        push("trig_one_cycle", 0); chk(32'(trig));

        // Four timer ticks: wrap on ticks 2 and 4
        tmr_tick = 1'b1;
        cyc(); push("tick1_step", 0); chk(32'(step));
        cyc(); push("tick2_step", 1); chk(32'(step));
        cyc(); push("tick3_step", 0); chk(32'(step));
        cyc(); push("tick4_step", 1); chk(32'(step));
        tmr_tick = 1'b0;
        push("tick4_pos", 2);    chk(32'(wave_pos));
        cyc();
        push("step_clear", 0);   chk(32'(step));
        rd(3'd3, 1'b1, r);
`ifdef WAVE_CH_READBACK_EN
        push("rd_off3_timer", 32'hFE); chk(32'(r));
`else
        push("rd_off3_timer", 32'hFF); chk(32'(r));
`endif

        // Length expiry after two ticks from 0xFE
        wr(3'd1, 8'hFE);
        wr(3'd4, 8'hC0);
        push("len_trig_active", 1); chk(32'(active));
        push("len_en_set", 1);   chk(32'(len_en));
        push("len_freq", 32'h0FE); chk(32'(freq));
        len_tick = 1'b1;
        cyc(); push("len_tick1_active", 1); chk(32'(active));
        cyc(); push("len_tick2_active", 0); chk(32'(active));
        len_tick = 1'b0;
        tmr_tick = 1'b1;
        repeat (3) cyc();
        tmr_tick = 1'b0;
        push("idle_pos_hold", 0); chk(32'(wave_pos));
        push("idle_no_step", 0);  chk(32'(step));

        // Retrigger after expiry restarts the count at 0: 256 ticks to expire
        wr(3'd4, 8'hC0);
        push("retrig_active", 1); chk(32'(active));
        len_tick = 1'b1;
        repeat (255) cyc();
        push("len_255_active", 1); chk(32'(active));
        cyc();
        push("len_256_active", 0); chk(32'(active));
        len_tick = 1'b0;

        // Trigger beats a same-cycle len_tick at len_cnt=0xFF
        wr(3'd1, 8'hFF);
        len_tick = 1'b1;
        wr(3'd4, 8'hC7);
        push("trig_len_tick_active", 1); chk(32'(active));
        push("trig_len_tick_pulse", 1);  chk(32'(trig));
        cyc();
        push("len_after_trig_expire", 0); chk(32'(active));
        len_tick = 1'b0;

        // Length write beats a same-cycle len_tick
        wr(3'd4, 8'hC7);
        push("retrig2_active", 1); chk(32'(active));
        len_tick = 1'b1;
        wr(3'd1, 8'hFE);
        cyc(); push("len_wr_prio_active", 1); chk(32'(active));
        cyc(); push("len_wr_prio_expire", 0); chk(32'(active));
        len_tick = 1'b0;

        // Disabling the DAC stops the channel; trigger still pulses
        wr(3'd0, 8'h80);
        wr(3'd4, 8'h87);
        push("dac_retrig_active", 1); chk(32'(active));
        wr(3'd0, 8'h00);
        push("dac_off_active", 0); chk(32'(active));
        wr(3'd4, 8'h80);
        push("dac_off_trig", 1);   chk(32'(trig));
        push("dac_off_trig_active", 0); chk(32'(active));
        cyc();
        push("dac_off_stays", 0);  chk(32'(active));

        // Readback of a freshly loaded timer 0x123
        wr(3'd0, 8'h80);
        wr(3'd3, 8'h23);
        wr(3'd4, 8'hC1);
        rd(3'd4, 1'b1, r);
`ifdef WAVE_CH_READBACK_EN
        push("rd_off4", 32'hC1); chk(32'(r));
`else
        push("rd_off4", 32'hFF); chk(32'(r));
`endif
        wr(3'd4, 8'h41);
        rd(3'd4, 1'b1, r);
`ifdef WAVE_CH_READBACK_EN
        push("rd_off4_lenen", 32'hC1); chk(32'(r));
`else
        push("rd_off4_lenen", 32'hFF); chk(32'(r));
`endif
        wr(3'd4, 8'h01);
        rd(3'd4, 1'b1, r);
`ifdef WAVE_CH_READBACK_EN
        push("rd_off4_nolen", 32'h81); chk(32'(r));
`else
        push("rd_off4_nolen", 32'hBF); chk(32'(r));
`endif
        rd(3'd5, 1'b1, r);
        push("rd_off5", 32'hFF); chk(32'(r));

        // Reset mid-count: step every tick with freq 0x7FF
        wr(3'd3, 8'hFF);
        wr(3'd4, 8'h87);
        tmr_tick = 1'b1;
        repeat (3) cyc();
        push("pre_rst_pos", 3);  chk(32'(wave_pos));
        #2;
        rst = 1'b1;
        #1;
        push("async_rst_active", 0); chk(32'(active));
        push("async_rst_pos", 0);    chk(32'(wave_pos));
        push("async_rst_freq", 0);   chk(32'(freq));
        push("async_rst_dac", 0);    chk(32'(dac_en));
        push("async_rst_len_en", 0); chk(32'(len_en));
        push("async_rst_vol", 0);    chk(32'(vol));
        push("async_rst_step", 0);   chk(32'(step));
        cyc();
        wr(3'd4, 8'h87);
        push("rst_ignores_wr", 0);   chk(32'(freq));
        tmr_tick = 1'b0;
        rst = 1'b0;
        cyc();
        push("post_rst_trig", 0);    chk(32'(trig));
        push("post_rst_active", 0);  chk(32'(active));
        push("post_rst_step", 0);    chk(32'(step));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wave_ch_ctrl.md
WAVE_CH_CTRL -- requirements
Module: wave_ch_ctrl

Interface
REQ-001 SHALL have parameter FREQ_W, default 11, frequency register/timer width, legal 9..14.
REQ-002 SHALL have parameter LEN_W, default 8, length counter width, legal 1..8.
REQ-003 SHALL have parameter VOL_W, default 2, volume code width, legal 1..3.
REQ-004 SHALL have parameter POS_W, default 5, wave sample position width, legal 1..8.
REQ-005 SHALL have ports: cery_2mhz in 1 clock; apu_reset in 1 reset; one clock, reset asynchronous and active-high.
REQ-006 SHALL have ports: wr_en in 1 write strobe; rd_en in 1 read strobe; addr in 3 register offset 0..4; wdata in 8 write data; rdata out 8 read data.
REQ-007 SHALL have ports: tmr_tick in 1 frequency-timer advance strobe; len_tick in 1 length-clock strobe.
REQ-008 SHALL have ports: dac_en out 1; vol out VOL_W; freq out FREQ_W; len_en out 1; active out 1; trig out 1 pulse; step out 1 pulse; wave_pos out POS_W.

Function
REQ-009 SHALL decode writes on wr_en at rising cery_2mhz: off0 bit7->dac_en; off1 wdata[LEN_W-1:0]->len_cnt, clear len_done; off2 wdata[VOL_W+4:5]->vol; off3 wdata[7:0]->freq[7:0]; off4 wdata[FREQ_W-9:0]->freq high, bit6->len_en, bit7=1 -> trigger.
REQ-010 SHALL ignore writes to offsets 5..7.
REQ-011 SHALL on trigger: set active iff dac_en=1; load freq timer with freq; clear wave_pos; if len_done, set len_cnt=0 and clear len_done; assert trig for exactly one cycle.
REQ-012 SHALL clear active in the cycle after a write of off0 bit7=0.
REQ-013 SHALL, on tmr_tick with active=1 and no trigger: if timer all-ones, reload freq, pulse step one cycle, wave_pos+1 modulo 2^POS_W; else timer+1.
REQ-014 SHALL hold timer, wave_pos and step=0 while active=0.
REQ-015 SHALL, on len_tick with len_en=1 and len_done=0: if len_cnt all-ones, set len_done, len_cnt=0, active=0; else len_cnt+1.
REQ-016 SHALL give trigger priority over same-cycle tmr_tick (no step) and len_tick (tick discarded).
REQ-017 SHALL give an off1 write priority over a same-cycle len_tick.
REQ-018 SHALL drive rdata combinationally: 0xFF when rd_en=0 or addr 5..7; off0 {dac_en,7'h7F}; off1 0xFF; off2 vol in [VOL_W+4:5], all other bits 1.
REQ-019 SHALL apply new register values to outputs one cycle after the write edge.

Reset
REQ-020 SHALL asynchronously clear all registers, len_cnt, len_done, timer, wave_pos, dac_en, vol, freq, len_en, active, trig, step while apu_reset=1.
REQ-021 SHALL ignore wr_en, tmr_tick, len_tick while apu_reset=1; a trigger in progress is lost, no trig/step pulse after release.

Configuration
REQ-022 SHALL use macro WAVE_CH_READBACK_EN.
REQ-023 SHALL with WAVE_CH_READBACK_EN defined: off3 reads live timer[7:0]; off4 reads {1, len_en, 0-padded timer high bits in [5:0], unused bits 1}.
REQ-024 SHALL without WAVE_CH_READBACK_EN: off3 reads 0xFF; off4 reads {1, len_en, 6'h3F}; no readback mux logic present.

Verification
REQ-025 Reset then write off0=0x80, off3=0xFE, off4=0x87 (FREQ_W=11) -> trig high one cycle, active=1, freq=0x7FE, wave_pos=0.
REQ-026 Active with freq=0x7FE, 4 tmr_ticks -> step pulses after ticks 2 and 4, wave_pos=2.
REQ-027 off1=0xFE, off4=0xC0 after trigger, 2 len_ticks -> active=0 after 2nd tick, len_cnt=0; next trigger -> active=1, len_cnt=0.
REQ-028 Trigger and len_tick same cycle with len_cnt=0xFF, len_en=1 -> no expiry, active=1.
REQ-029 Write off0=0x00 while active, then off4=0x80 -> active=0 and stays 0, trig still pulses.
REQ-030 Read off4 with len_en=1, timer=0x123 -> 0xC1 with WAVE_CH_READBACK_EN, 0xFF without; apu_reset mid-count -> all outputs 0 immediately.
